// File: rtl/cam_capture_if.sv
// Pixel-stream input and frame-buffer write port for cam_capture.
// slave = the capture block, master = camera/memory side.
interface cam_capture_if #(
    parameter int ADDR_W = 17
);
    logic [7:0]        in_value;
    logic [9:0]        in_x;
    logic [9:0]        in_y;
    logic              in_is_val;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              wr_ready;

    modport slave (
        input  in_value, in_x, in_y, in_is_val, wr_ready,
        output wr_addr, wr_data, wr_valid
    );

    modport master (
        output in_value, in_x, in_y, in_is_val, wr_ready,
        input  wr_addr, wr_data, wr_valid
    );
endinterface

// File: rtl/cam_capture.sv
// Captures one camera frame into frame-buffer memory through a small show-ahead write FIFO.
// Optional macro CAM_CAPTURE_CHECKSUM_EN adds a per-frame 16-bit pixel sum on frame_sum.
//
// state    | meaning
// IDLE     | disarmed, pixels ignored
// WAIT_SOF | armed, waiting for pixel (0,0)
// CAPTURE  | accepting in-range pixels until the last one of the frame
// DRAIN    | frame ended, emptying FIFO, then frame_done
// ABORT    | enable dropped mid-frame, emptying FIFO without frame_done
module cam_capture #(
    parameter int ROW_SZ     = 320,
    parameter int COL_SZ     = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    cam_capture_if.slave bus,
    output logic        capturing,
    output logic        frame_done,
    output logic [15:0] overflow_cnt,
    output logic [15:0] frame_sum
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN, ABORT} state_t;
    state_t state;

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [7:0]        mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count;
    logic              empty, full, in_range, is_sof, is_last, accept, push, pop;
    logic [31:0]       addr_full;

    assign in_range  = (32'(bus.in_x) < 32'(ROW_SZ)) && (32'(bus.in_y) < 32'(COL_SZ));
    assign is_sof    = bus.in_is_val && (bus.in_x == '0) && (bus.in_y == '0);
    assign is_last   = bus.in_is_val && (32'(bus.in_x) == 32'(ROW_SZ - 1))
                       && (32'(bus.in_y) == 32'(COL_SZ - 1));
    assign accept    = bus.in_is_val && in_range && enable
                       && ((state == CAPTURE) || ((state == WAIT_SOF) && is_sof));
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    // Full is judged on the registered count, so a same-cycle pop does not make room.
    assign push      = accept && !full;
    assign pop       = !empty && bus.wr_ready;
    assign addr_full = 32'(bus.in_y) * 32'(ROW_SZ) + 32'(bus.in_x);

    assign bus.wr_valid = !empty;
    assign bus.wr_addr  = empty ? '0 : mem_addr[rptr];
    assign bus.wr_data  = empty ? '0 : mem_data[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wptr] <= addr_full[ADDR_W-1:0];
            mem_data[wptr] <= bus.in_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (accept && full && (overflow_cnt != 16'hFFFF))
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            capturing  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= WAIT_SOF;
                        capturing <= 1'b1;
                    end
                end
                WAIT_SOF: begin
                    if (!enable) begin
                        state     <= ABORT;
                        capturing <= 1'b0;
                    end else if (is_sof) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!enable) begin
                        state     <= ABORT;
                        capturing <= 1'b0;
                    end else if (is_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        frame_done <= 1'b1;
                        state      <= enable ? WAIT_SOF : IDLE;
                        capturing  <= enable;
                    end
                end
                ABORT: begin
                    if (empty) state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    capturing <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAM_CAPTURE_CHECKSUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else begin
            if ((state == WAIT_SOF) && accept)
                sum_acc <= push ? {8'h00, bus.in_value} : 16'h0000;
            else if (push)
                sum_acc <= sum_acc + {8'h00, bus.in_value};
            if ((state == DRAIN) && empty)
                frame_sum <= sum_acc;
        end
    end
`else
    assign frame_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_cam_capture;
    localparam int ROW_SZ     = 4;
    localparam int COL_SZ     = 3;
    localparam int ADDR_W     = 17;
    localparam int FIFO_DEPTH = 4;
`ifdef CAM_CAPTURE_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_DRAIN = 3, M_ABORT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        capturing, frame_done;
    logic [15:0] overflow_cnt, frame_sum;

    cam_capture_if #(.ADDR_W(ADDR_W)) bus ();

    cam_capture #(
        .ROW_SZ(ROW_SZ), .COL_SZ(COL_SZ), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus),
        .capturing(capturing), .frame_done(frame_done),
        .overflow_cnt(overflow_cnt), .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data;} wr_t;
    typedef struct {
        bit en; bit val; int x; int y; int value; bit rdy;
        bit exp_valid; int exp_addr; int exp_data; bit exp_done;
    } vec_t;

    wr_t q[$];
    int  m_mode, m_ovf, m_acc, m_sum;
    bit  m_done;
    int  checks = 0, errors = 0;
    int  dut_writes = 0, dut_dones = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_mode = M_IDLE;
        m_ovf  = 0;
        m_acc  = 0;
        m_sum  = 0;
        m_done = 1'b0;
    endtask

    task automatic do_reset();
        enable        = 1'b0;
        bus.in_is_val = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_value  = '0;
        bus.wr_ready  = 1'b0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic compare_all();
        bit cap_exp;
        cap_exp = (m_mode == M_WAIT) || (m_mode == M_CAP) || (m_mode == M_DRAIN);
        check("wr_valid", 32'(bus.wr_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("wr_addr", 32'(bus.wr_addr), q[0].addr);
            check("wr_data", 32'(bus.wr_data), q[0].data);
        end
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("capturing", 32'(capturing), 32'(cap_exp));
        check("overflow_cnt", 32'(overflow_cnt), m_ovf);
        check("frame_sum", 32'(frame_sum), m_sum);
    endtask

    // Drive one cycle of inputs, advance the model by one clock, then compare.
    task automatic cycle(input bit en, input bit val, input int x, input int y,
                         input int value, input bit rdy);
        int  pre;
        bit  sof, acc;
        wr_t w;
        enable        = en;
        bus.in_is_val = val;
        bus.in_x      = 10'(x);
        bus.in_y      = 10'(y);
        bus.in_value  = 8'(value);
        bus.wr_ready  = rdy;
        if (bus.wr_valid && rdy) dut_writes++;
        @(posedge clk);
        pre    = q.size();
        sof    = val && (x == 0) && (y == 0);
        acc    = val && (x < ROW_SZ) && (y < COL_SZ) && en
                 && ((m_mode == M_CAP) || ((m_mode == M_WAIT) && sof));
        m_done = 1'b0;
        if (pre > 0 && rdy) void'(q.pop_front());
        if (acc) begin
            if (pre < FIFO_DEPTH) begin
                w.addr = y * ROW_SZ + x;
                w.data = value & 255;
                q.push_back(w);
                m_acc = (m_mode == M_WAIT) ? (value & 255) : ((m_acc + (value & 255)) & 16'hFFFF);
            end else begin
                if (m_ovf < 65535) m_ovf++;
                if (m_mode == M_WAIT) m_acc = 0;
            end
        end
        case (m_mode)
            M_IDLE:  if (en) m_mode = M_WAIT;
            M_WAIT:  if (!en) m_mode = M_ABORT; else if (sof) m_mode = M_CAP;
            M_CAP:   if (!en) m_mode = M_ABORT;
                     else if (val && x == ROW_SZ - 1 && y == COL_SZ - 1) m_mode = M_DRAIN;
            M_DRAIN: if (pre == 0) begin
                         m_done = 1'b1;
                         m_sum  = CHK ? m_acc : 0;
                         m_mode = en ? M_WAIT : M_IDLE;
                     end
            M_ABORT: if (pre == 0) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        @(negedge clk);
        compare_all();
        if (frame_done) dut_dones++;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   k, pos, en_low;
        bit   en_r, val_r;
        int   x_r, y_r;

        // Test 1 vectors: alternate valid cycles, full-rate ready
        v = '{en:1, val:0, x:0, y:0, value:0, rdy:1, exp_valid:0, exp_addr:0, exp_data:0, exp_done:0};
        tbl.push_back(v);
        for (int i = 0; i < ROW_SZ * COL_SZ; i++) begin
            v = '{en:1, val:1, x:i % ROW_SZ, y:i / ROW_SZ, value:i, rdy:1,
                  exp_valid:1, exp_addr:i, exp_data:i, exp_done:0};
            tbl.push_back(v);
            v = '{en:1, val:0, x:0, y:0, value:0, rdy:1, exp_valid:0, exp_addr:0, exp_data:0, exp_done:0};
            tbl.push_back(v);
        end
        v.exp_done = 1'b1;
        tbl.push_back(v);
        v.exp_done = 1'b0;
        tbl.push_back(v);

        do_reset();
        check("rst_wr_valid", 32'(bus.wr_valid), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_capturing", 32'(capturing), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overflow", 32'(overflow_cnt), 0);
        check("rst_frame_sum", 32'(frame_sum), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].en, tbl[i].val, tbl[i].x, tbl[i].y, tbl[i].value, tbl[i].rdy);
            check("t1_valid", 32'(bus.wr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check("t1_addr", 32'(bus.wr_addr), tbl[i].exp_addr);
                check("t1_data", 32'(bus.wr_data), tbl[i].exp_data);
            end
            check("t1_done", 32'(frame_done), 32'(tbl[i].exp_done));
        end
        check("t1_sum", 32'(frame_sum), CHK ? 66 : 0);
        check("t1_overflow", 32'(overflow_cnt), 0);

        // Test 2: stream starts mid-frame
        do_reset();
        dut_writes = 0;
        dut_dones  = 0;
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 6; i < 24; i++) begin
            k = i % (ROW_SZ * COL_SZ);
            cycle(1, 1, k % ROW_SZ, k / ROW_SZ, k, 1);
        end
        repeat (4) cycle(1, 0, 0, 0, 0, 1);
        check("t2_writes", dut_writes, 12);
        check("t2_dones", dut_dones, 1);

        // Test 3: memory stalled for the whole frame
        do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < ROW_SZ * COL_SZ; i++)
            cycle(1, 1, i % ROW_SZ, i / ROW_SZ, i, 0);
        check("t3_overflow", 32'(overflow_cnt), 8);
        check("t3_hold_addr", 32'(bus.wr_addr), 0);
        check("t3_hold_data", 32'(bus.wr_data), 0);
        dut_writes = 0;
        dut_dones  = 0;
        repeat (8) cycle(1, 0, 0, 0, 0, 1);
        check("t3_writes", dut_writes, 4);
        check("t3_dones", dut_dones, 1);

        // Test 5: async reset with three queued writes
        for (int i = 0; i < 3; i++) cycle(1, 1, i, 0, 40 + i, 0);
        check("t5_queued", 32'(bus.wr_valid), 1);
        #2 reset = 1'b1;
        #1;
        check("t5_wr_valid", 32'(bus.wr_valid), 0);
        check("t5_wr_addr", 32'(bus.wr_addr), 0);
        check("t5_wr_data", 32'(bus.wr_data), 0);
        check("t5_capturing", 32'(capturing), 0);
        check("t5_overflow", 32'(overflow_cnt), 0);
        check("t5_frame_sum", 32'(frame_sum), 0);
        do_reset();

        // Test 4: enable dropped after 5 accepted pixels
        dut_writes = 0;
        dut_dones  = 0;
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, i % ROW_SZ, i / ROW_SZ, i, 1'(i % 2));
        for (int i = 5; i < 17; i++) begin
            k = i % (ROW_SZ * COL_SZ);
            cycle(0, 1, k % ROW_SZ, k / ROW_SZ, k, 1);
        end
        check("t4_writes", dut_writes, 5);
        check("t4_dones", dut_dones, 0);
        check("t4_capturing", 32'(capturing), 0);

        // Randomized traffic against the model
        do_reset();
        dut_dones = 0;
        pos       = 0;
        en_low    = 0;
        for (int i = 0; i < 3000; i++) begin
            if (en_low == 0 && $urandom_range(0, 299) == 0) en_low = $urandom_range(1, 6);
            en_r = (en_low == 0);
            if (en_low > 0) en_low--;
            val_r = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) begin
                x_r = $urandom_range(0, ROW_SZ + 1);
                y_r = $urandom_range(0, COL_SZ + 1);
            end else begin
                x_r = pos % ROW_SZ;
                y_r = pos / ROW_SZ;
                if (val_r) pos = (pos + 1) % (ROW_SZ * COL_SZ);
            end
            cycle(en_r, val_r, x_r, y_r, $urandom_range(0, 255), ($urandom_range(0, 3) != 0));
        end
        check("rand_frames_seen", 32'(dut_dones > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
